add64_sequencer: RTL and testbench

Multi-cycle controller that computes a WIDTH-bit add by sequencing one narrow SLICE-bit adder over WIDTH/SLICE cycles, least-significant slice first, with a registered carry between cycles. It trades latency for area against the full-width look-ahead adder. It sits between a requester using a start/ready/done handshake and the shared slice datapath.

---
 rtl/add64_sequencer_pkg.sv | 20 ++
 rtl/add64_sequencer_if.sv | 31 +++
 rtl/add64_sequencer_slice_adder.sv | 15 +
 rtl/add64_sequencer.sv | 124 ++++++++++++
 tb/tb_add64_sequencer.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/add64_sequencer_pkg.sv
// Shared types and sizing helpers for the sliced multi-cycle adder.
package add_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Number of adder passes needed to cover the full operand width.
    function automatic int unsigned num_slices(input int unsigned width, input int unsigned slice);
        return width / slice;
    endfunction

    // Slice counter width; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/add64_sequencer_if.sv
// Requester-side handshake and operand/result bus of the sliced adder.
// The sub input exists only when ADD64_SEQ_SUB_EN is defined.
interface add64_sequencer_if #(
    parameter int unsigned WIDTH = 64
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
`ifdef ADD64_SEQ_SUB_EN
    logic             sub;
`endif
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;

`ifdef ADD64_SEQ_SUB_EN
    modport master (output start, a, b, carry_in, sub,
                    input  ready, busy, done, sum, carry);
    modport slave  (input  start, a, b, carry_in, sub,
                    output ready, busy, done, sum, carry);
`else
    modport master (output start, a, b, carry_in,
                    input  ready, busy, done, sum, carry);
    modport slave  (input  start, a, b, carry_in,
                    output ready, busy, done, sum, carry);
`endif

endinterface

// File: rtl/add64_sequencer_slice_adder.sv
// Combinational SLICE-bit ripple adder shared across all passes.
module slice_adder #(
    parameter int unsigned SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             carry_in,
    output logic [SLICE-1:0] sum,
    output logic             carry_out
);

    // One extra bit captures the carry out of the slice.
    assign {carry_out, sum} = (SLICE+1)'(a) + (SLICE+1)'(b) + (SLICE+1)'(carry_in);

endmodule

// File: rtl/add64_sequencer.sv
// Multi-cycle WIDTH-bit adder: one SLICE-bit adder is reused over
// WIDTH/SLICE cycles, LSB slice first, with a registered inter-slice carry.
// Optional macro ADD64_SEQ_SUB_EN adds a sub input (A-B via ~B and carry 1).
module add64_sequencer
    import add_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SLICE = 8
) (
    input  logic          clk,
    input  logic          reset,
    add64_sequencer_if.slave bus
);

    localparam int unsigned NUM_SLICES = num_slices(WIDTH, SLICE);
    localparam int unsigned CNT_W      = cnt_w(NUM_SLICES);
    localparam int unsigned IDX_W      = (WIDTH <= 1) ? 1 : $clog2(WIDTH);

    // Reject configurations that leave a partial top slice.
    if ((WIDTH % SLICE) != 0) begin : g_bad_slice
        $error("add64_sequencer: WIDTH must be a multiple of SLICE");
    end

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   sum_q;
    logic               carry_out_q;
    logic               ready_q;
    logic               busy_q;
    logic               done_q;

    logic               accept_c;
    logic               last_c;
    logic [IDX_W-1:0]   base_c;
    logic [SLICE-1:0]   slice_a_c;
    logic [SLICE-1:0]   slice_b_c;
    logic [SLICE-1:0]   slice_s_c;
    logic               slice_co_c;
    logic [WIDTH-1:0]   b_load_c;
    logic               c_load_c;

    // Operand conditioning at accept: subtract folds into ~B plus carry 1.
`ifdef ADD64_SEQ_SUB_EN
    assign b_load_c = bus.sub ? ~bus.b : bus.b;
    assign c_load_c = bus.sub ? 1'b1   : bus.carry_in;
`else
    assign b_load_c = bus.b;
    assign c_load_c = bus.carry_in;
`endif

    assign accept_c = bus.start && ((state == IDLE) || (state == FIN));
    assign last_c   = (cnt == CNT_W'(NUM_SLICES - 1));

    // Select the current slice of each operand.
    always_comb begin
        base_c    = IDX_W'(cnt * SLICE);
        slice_a_c = a_q[base_c +: SLICE];
        slice_b_c = b_q[base_c +: SLICE];
    end

    slice_adder #(.SLICE(SLICE)) u_slice_adder (
        .a         (slice_a_c),
        .b         (slice_b_c),
        .carry_in  (carry_q),
        .sum       (slice_s_c),
        .carry_out (slice_co_c)
    );

    // Next-state logic; START is only honoured in IDLE and FIN.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept_c) next_state = RUN;
            RUN:     if (last_c)   next_state = FIN;
            FIN:     next_state = accept_c ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            cnt         <= '0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state   <= next_state;
            ready_q <= (next_state != RUN);
            busy_q  <= (next_state == RUN);
            done_q  <= (next_state == FIN);
            if (accept_c) begin
                a_q     <= bus.a;
                b_q     <= b_load_c;
                carry_q <= c_load_c;
                cnt     <= '0;
            end else if (state == RUN) begin
                sum_q[base_c +: SLICE] <= slice_s_c;
                carry_q                <= slice_co_c;
                cnt                    <= last_c ? '0 : cnt + CNT_W'(1);
                if (last_c) begin
                    carry_out_q <= slice_co_c;
                end
            end
        end
    end

    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sum   = sum_q;
    assign bus.carry = carry_out_q;

endmodule

// File: tb/tb_add64_sequencer.sv
// Directed self-checking bench for add64_sequencer (default 64/8 build).
module tb_add64_sequencer;

    localparam int unsigned WIDTH = 64;
    localparam int unsigned SLICE = 8;
    localparam int          LAT   = 8;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    add64_sequencer_if #(.WIDTH(WIDTH)) bus ();

    add64_sequencer #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic ci, input logic sub);
        bus.start    = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.carry_in = ci;
`ifdef ADD64_SEQ_SUB_EN
        bus.sub      = sub;
`else
        if (sub) $display("[TB] sub requested in add-only build");
`endif
    endtask

    // Wait for DONE; lat = edges after the accept edge, 0 on timeout.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tests++; if (bus.ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", bus.ready); end
        tests++; if (bus.busy  !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        tests++; if (bus.done  !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", bus.done); end
        tests++; if (bus.sum   !== 64'h0) begin fails++; $display("FAIL reset_sum got %h exp 0", bus.sum); end
        tests++; if (bus.carry !== 1'b0) begin fails++; $display("FAIL reset_carry got %b exp 0", bus.carry); end
    endtask

    task automatic test_basic_add();
        int lat;
        drive_op(64'h1, 64'h2, 1'b0, 1'b0);
        tick();
        bus.start = 1'b0;
        tests++; if (bus.busy !== 1'b1 || bus.ready !== 1'b0) begin
            fails++; $display("FAIL basic_busy got busy=%b ready=%b exp busy=1 ready=0", bus.busy, bus.ready); end
        wait_done(lat);
        tests++; if (lat !== LAT) begin fails++; $display("FAIL basic_latency got %0d exp %0d", lat, LAT); end
        tests++; if (bus.sum !== 64'h3) begin fails++; $display("FAIL basic_sum got %h exp 3", bus.sum); end
        tests++; if (bus.carry !== 1'b0) begin fails++; $display("FAIL basic_carry got %b exp 0", bus.carry); end
        tests++; if (bus.ready !== 1'b1 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL basic_fin_status got ready=%b busy=%b exp 1/0", bus.ready, bus.busy); end
        tick();
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL basic_done_pulse got %b exp 0", bus.done); end
        tests++; if (bus.sum !== 64'h3) begin fails++; $display("FAIL basic_sum_hold got %h exp 3", bus.sum); end
    endtask

    task automatic test_carry_chain();
        int lat;
        drive_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
        tick();
        bus.start = 1'b0;
        tests++; if (bus.sum !== 64'h3) begin fails++; $display("FAIL chain_prev_hold got %h exp 3", bus.sum); end
        wait_done(lat);
        tests++; if (lat !== LAT) begin fails++; $display("FAIL chain_latency got %0d exp %0d", lat, LAT); end
        tests++; if (bus.sum !== 64'h0) begin fails++; $display("FAIL chain_sum got %h exp 0", bus.sum); end
        tests++; if (bus.carry !== 1'b1) begin fails++; $display("FAIL chain_carry got %b exp 1", bus.carry); end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        drive_op(64'd5, 64'd7, 1'b0, 1'b0);
        tick();
        bus.a = 64'h8000_0000_0000_0000;
        bus.b = 64'h8000_0000_0000_0000;
        wait_done(lat);
        tests++; if (lat !== LAT) begin fails++; $display("FAIL b2b_first_latency got %0d exp %0d", lat, LAT); end
        tests++; if (bus.sum !== 64'd12) begin fails++; $display("FAIL b2b_first_sum got %h exp c", bus.sum); end
        tests++; if (bus.carry !== 1'b0) begin fails++; $display("FAIL b2b_first_carry got %b exp 0", bus.carry); end
        tick();
        bus.start = 1'b0;
        tests++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            fails++; $display("FAIL b2b_fin_accept got busy=%b done=%b exp 1/0", bus.busy, bus.done); end
        wait_done(lat);
        tests++; if (lat !== LAT) begin fails++; $display("FAIL b2b_second_latency got %0d exp %0d", lat, LAT); end
        tests++; if (bus.sum !== 64'h0) begin fails++; $display("FAIL b2b_second_sum got %h exp 0", bus.sum); end
        tests++; if (bus.carry !== 1'b1) begin fails++; $display("FAIL b2b_second_carry got %b exp 1", bus.carry); end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int seen;
        drive_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++; if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            fails++; $display("FAIL abort_status got ready=%b busy=%b done=%b exp 1/0/0", bus.ready, bus.busy, bus.done); end
        tests++; if (bus.sum !== 64'h0 || bus.carry !== 1'b0) begin
            fails++; $display("FAIL abort_result got sum=%h carry=%b exp 0/0", bus.sum, bus.carry); end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL abort_no_done got %0d active cycles exp 0", seen); end
        drive_op(64'd1, 64'd1, 1'b0, 1'b0);
        tick();
        bus.start = 1'b0;
        wait_done(lat);
        tests++; if (lat !== LAT) begin fails++; $display("FAIL abort_next_latency got %0d exp %0d", lat, LAT); end
        tests++; if (bus.sum !== 64'd2 || bus.carry !== 1'b0) begin
            fails++; $display("FAIL abort_next_sum got sum=%h carry=%b exp 2/0", bus.sum, bus.carry); end
        tick();
    endtask

`ifdef ADD64_SEQ_SUB_EN
    task automatic test_sub();
        int lat;
        drive_op(64'd10, 64'd3, 1'b0, 1'b1);
        tick();
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        wait_done(lat);
        tests++; if (bus.sum !== 64'd7 || bus.carry !== 1'b1) begin
            fails++; $display("FAIL sub_pos got sum=%h carry=%b exp 7/1", bus.sum, bus.carry); end
        tick();
        drive_op(64'd3, 64'd10, 1'b0, 1'b1);
        tick();
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        wait_done(lat);
        tests++; if (bus.sum !== 64'hFFFF_FFFF_FFFF_FFF9 || bus.carry !== 1'b0) begin
            fails++; $display("FAIL sub_neg got sum=%h carry=%b exp fffffffffffffff9/0", bus.sum, bus.carry); end
        tick();
    endtask
`endif

    initial begin
        tests        = 0;
        fails        = 0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.carry_in = 1'b0;
`ifdef ADD64_SEQ_SUB_EN
        bus.sub      = 1'b0;
`endif
        test_reset();
        test_basic_add();
        test_carry_chain();
        test_back_to_back();
        test_reset_mid_run();
`ifdef ADD64_SEQ_SUB_EN
        test_sub();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
